// File: rtl/instr_buffer_pkg.sv
// Shared CPU constants used by the instruction buffer.
package instr_buffer_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int IB_DEPTH    = 4;

endpackage

// File: rtl/instr_buffer_ram.sv
// DEPTH x DATA_W storage: one falling-edge write port, one combinational read port.
module instr_buffer_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry on the falling edge; contents are never reset.
    always_ff @(negedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between instruction fetch and decode.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH,
    parameter int DEPTH = IB_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IRWre,
    input  logic [WIDTH-1:0] InstructionIn,
    input  logic [WIDTH-1:0] PCIn,
    input  logic             Pop,
    input  logic             Flush,
    output logic [WIDTH-1:0] IRReg,
    output logic [WIDTH-1:0] PCReg,
    output logic             Valid,
    output logic             Full,
    output logic [CW-1:0]    Count,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               overflow;
    logic               underflow;
    logic               push;
    logic               pop;
    logic               drop;
    logic               empty_pop;
    logic [2*WIDTH-1:0] rd_data;

    // Status comes from registered state only.
    assign Valid = (count != '0);
    assign Full  = (count == CW'(DEPTH));
    assign Count = count;

    assign Overflow  = overflow;
    assign Underflow = underflow;

    // Qualify requests; a full buffer still accepts a push when the head leaves on the same edge.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        empty_pop = 1'b0;
        if (!Flush) begin
            push      = IRWre && (!Full || Pop);
            pop       = Pop && Valid;
            drop      = IRWre && Full && !Pop;
            empty_pop = Pop && !Valid;
        end
    end

    // Pointer, occupancy and sticky error flag update on the falling edge.
    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (Flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            overflow  <= overflow  | drop;
            underflow <= underflow | empty_pop;
        end
    end

    instr_buffer_ram #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .CLK   (CLK),
        .we    (push && Reset),
        .waddr (wr_ptr),
        .wdata ({InstructionIn, PCIn}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Head entry is presented only while something is buffered.
    always_comb begin
        IRReg = '0;
        PCReg = '0;
        if (Valid) begin
            IRReg = rd_data[2*WIDTH-1:WIDTH];
            PCReg = rd_data[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer (WIDTH=32, DEPTH=4).
module tb_instr_buffer;

    logic        CLK;
    logic        Reset;
    logic        IRWre;
    logic [31:0] InstructionIn;
    logic [31:0] PCIn;
    logic        Pop;
    logic        Flush;
    logic [31:0] IRReg;
    logic [31:0] PCReg;
    logic        Valid;
    logic        Full;
    logic [2:0]  Count;
    logic        Overflow;
    logic        Underflow;

    int total = 0;
    int bad   = 0;

    instr_buffer #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .IRWre         (IRWre),
        .InstructionIn (InstructionIn),
        .PCIn          (PCIn),
        .Pop           (Pop),
        .Flush         (Flush),
        .IRReg         (IRReg),
        .PCReg         (PCReg),
        .Valid         (Valid),
        .Full          (Full),
        .Count         (Count),
        .Overflow      (Overflow),
        .Underflow     (Underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one set of inputs across a falling edge, then settle 1 time unit past it.
    task automatic drive(input logic w, input logic [31:0] ins, input logic [31:0] pc,
                         input logic p, input logic f);
        IRWre = w; InstructionIn = ins; PCIn = pc; Pop = p; Flush = f;
        @(negedge CLK);
        #1;
        IRWre = 1'b0; Pop = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; IRWre = 1'b0; Pop = 1'b0; Flush = 1'b0;
        InstructionIn = '0; PCIn = '0;
        #1 Reset = 1'b0;
        #2;
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Valid); end
        total++; if (Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", Full); end
        total++; if ({Overflow, Underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {Overflow, Underflow}); end
        total++; if ({IRReg, PCReg} !== 64'd0) begin bad++; $display("FAIL reset_head got=%h exp=0", {IRReg, PCReg}); end
        // release between edges; first update happens on the next falling edge
        @(posedge CLK); #2 Reset = 1'b1;
        @(negedge CLK); #1;
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL reset_release_count got=%0d exp=0", Count); end
    endtask

    task automatic test_in_order();
        logic [31:0] words [3];
        words[0] = 32'h8C010004; words[1] = 32'h00221820; words[2] = 32'hAC030008;
        drive(1'b1, words[0], 32'h0, 1'b0, 1'b0);
        total++; if (IRReg !== 32'h8C010004) begin bad++; $display("FAIL first_word_latency got=%h exp=8c010004", IRReg); end
        drive(1'b1, words[1], 32'h4, 1'b0, 1'b0);
        drive(1'b1, words[2], 32'h8, 1'b0, 1'b0);
        total++; if (Count !== 3'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", Count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (IRReg !== words[i]) begin bad++; $display("FAIL order_ir[%0d] got=%h exp=%h", i, IRReg, words[i]); end
            total++; if (PCReg !== 32'(i * 4)) begin bad++; $display("FAIL order_pc[%0d] got=%h exp=%h", i, PCReg, i * 4); end
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL order_empty_valid got=%b exp=0", Valid); end
        total++; if (IRReg !== 32'd0) begin bad++; $display("FAIL order_empty_ir got=%h exp=0", IRReg); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0000000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            if (i == 3) begin
                total++; if ({Full, Count} !== {1'b1, 3'd4}) begin bad++; $display("FAIL ovf_full_after4 got=%b/%0d exp=1/4", Full, Count); end
                total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", Overflow); end
            end
        end
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", Count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (IRReg !== 32'hA0000000 + 32'(i)) begin bad++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, IRReg, 32'hA0000000 + 32'(i)); end
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        total++; if ({Valid, Overflow} !== 2'b01) begin bad++; $display("FAIL ovf_sticky got=%b exp=01", {Valid, Overflow}); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_flush_clear got=%b exp=0", Overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hB0000000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        drive(1'b1, 32'hB0000004, 32'h210, 1'b1, 1'b0);
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL b2b_count1 got=%0d exp=4", Count); end
        total++; if (IRReg !== 32'hB0000001) begin bad++; $display("FAIL b2b_head1 got=%h exp=b0000001", IRReg); end
        drive(1'b1, 32'hB0000005, 32'h214, 1'b1, 1'b0);
        total++; if ({Full, Count} !== {1'b1, 3'd4}) begin bad++; $display("FAIL b2b_count2 got=%b/%0d exp=1/4", Full, Count); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL b2b_no_ovf got=%b exp=0", Overflow); end
        for (int i = 2; i < 6; i++) begin
            total++; if (IRReg !== 32'hB0000000 + 32'(i)) begin bad++; $display("FAIL b2b_pop[%0d] got=%h exp=%h", i, IRReg, 32'hB0000000 + 32'(i)); end
            total++; if (PCReg !== 32'h200 + 32'(i * 4)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, PCReg, 32'h200 + 32'(i * 4)); end
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", Count); end
    endtask

    task automatic test_underflow();
        drive(1'b1, 32'h12345678, 32'h300, 1'b1, 1'b0);
        total++; if (Underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", Underflow); end
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL udf_count got=%0d exp=1", Count); end
        total++; if (IRReg !== 32'h12345678) begin bad++; $display("FAIL udf_ir got=%h exp=12345678", IRReg); end
    endtask

    task automatic test_flush();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        total++; if ({Count, Underflow} !== {3'd0, 1'b0}) begin bad++; $display("FAIL flush_clear_udf got=%0d/%b exp=0/0", Count, Underflow); end
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0000000 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        total++; if ({Count, Overflow} !== {3'd3, 1'b1}) begin bad++; $display("FAIL flush_setup got=%0d/%b exp=3/1", Count, Overflow); end
        drive(1'b1, 32'hDEADBEEF, 32'h500, 1'b0, 1'b1);
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", Count); end
        total++; if ({Valid, Overflow} !== 2'b00) begin bad++; $display("FAIL flush_flags got=%b exp=00", {Valid, Overflow}); end
        total++; if (IRReg !== 32'd0) begin bad++; $display("FAIL flush_ir got=%h exp=0", IRReg); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hE0000000, 32'h600, 1'b0, 1'b0);
        drive(1'b1, 32'hE0000001, 32'h604, 1'b0, 1'b0);
        total++; if (Count !== 3'd2) begin bad++; $display("FAIL areset_setup got=%0d exp=2", Count); end
        // move to just after the rising edge so no falling edge is near
        @(posedge CLK); #2;
        Reset = 1'b0;
        #1;
        total++; if ({Valid, Count} !== 4'd0) begin bad++; $display("FAIL areset_immediate got=%b/%0d exp=0/0", Valid, Count); end
        total++; if ({IRReg, PCReg} !== 64'd0) begin bad++; $display("FAIL areset_head got=%h exp=0", {IRReg, PCReg}); end
        IRWre = 1'b1; InstructionIn = 32'hBADBAD00; PCIn = 32'h700; Pop = 1'b1;
        @(negedge CLK); #1;
        IRWre = 1'b0; Pop = 1'b0;
        total++; if ({Count, Underflow} !== {3'd0, 1'b0}) begin bad++; $display("FAIL areset_ignore got=%0d/%b exp=0/0", Count, Underflow); end
        Reset = 1'b1;
        drive(1'b1, 32'hF0000000, 32'h800, 1'b0, 1'b0);
        total++; if ({IRReg, PCReg} !== {32'hF0000000, 32'h800}) begin bad++; $display("FAIL areset_next_push got=%h exp=f000000000000800", {IRReg, PCReg}); end
        total++; if (dut.rd_ptr !== 2'd0) begin bad++; $display("FAIL areset_entry0 got=%0d exp=0", dut.rd_ptr); end
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL areset_count got=%0d exp=1", Count); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
